// File: rtl/pmc_pkg.sv
// rtl/pmc_pkg.sv - shared types and constants for the PMC control sequencer
// Purpose: command and FSM state encodings plus dump word indices used by
//          pmc_ctrl, pmc_window_timer and their bench.
// Ports:   none (package)
package pmc_pkg;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_STOP  = 2'd1,
    CMD_CLEAR = 2'd2,
    CMD_DUMP  = 2'd3
  } pmc_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
    ST_DUMP = 2'd2
  } pmc_state_e;

  localparam logic [1:0] IDX_STALL = 2'd0;
  localparam logic [1:0] IDX_INSTR = 2'd1;
  localparam logic [1:0] IDX_ARITH = 2'd2;
  localparam logic [1:0] IDX_MEM   = 2'd3;

endpackage

// File: rtl/pmc_ctrl_if.sv
// rtl/pmc_ctrl_if.sv - command, counter and dump bundle for pmc_ctrl
// Purpose: groups the command port, live counter inputs, PMC unit controls
//          and the dump stream into one interface.
// Ports:   cmd_valid/cmd_op/cmd_ready   command handshake
//          *_count                      live counters from the PMC unit
//          pmc_enable/pmc_clear         controls to the PMC unit
//          dump_valid/ready/data/idx/last, dump_overrun  snapshot stream
// Modports: slave = pmc_ctrl side, master = driver/consumer side.
interface pmc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic             cmd_ready;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] instr_cycle_count;
  logic [CNT_W-1:0] arith_count;
  logic [CNT_W-1:0] mem_access_count;
  logic             pmc_enable;
  logic             pmc_clear;
  logic             dump_valid;
  logic             dump_ready;
  logic [CNT_W-1:0] dump_data;
  logic [1:0]       dump_idx;
  logic             dump_last;
  logic             dump_overrun;

  modport slave (
    input  cmd_valid, cmd_op, stall_count, instr_cycle_count, arith_count,
           mem_access_count, dump_ready,
    output cmd_ready, pmc_enable, pmc_clear, dump_valid, dump_data, dump_idx,
           dump_last, dump_overrun
  );

  modport master (
    output cmd_valid, cmd_op, stall_count, instr_cycle_count, arith_count,
           mem_access_count, dump_ready,
    input  cmd_ready, pmc_enable, pmc_clear, dump_valid, dump_data, dump_idx,
           dump_last, dump_overrun
  );
endinterface

// File: rtl/pmc_window_timer.sv
// rtl/pmc_window_timer.sv - periodic auto-dump window timer
// Purpose: counts run cycles and pulses o_expire on the last cycle of each
//          WINDOW_CYCLES-long window; WINDOW_CYCLES=0 disables it.
// Ports:   clk, rst_n  clock, async active-low reset
//          i_run       counting enabled (timer holds when low)
//          i_clear     zero the timer (and suppress expiry this cycle)
//          o_expire    one-cycle window expiry pulse
module pmc_window_timer #(
  parameter int unsigned WINDOW_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  input  logic i_clear,
  output logic o_expire
);
  localparam int unsigned TW     = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int unsigned LAST_I = (WINDOW_CYCLES > 0) ? WINDOW_CYCLES - 1 : 0;
  localparam logic [TW-1:0] LAST = TW'(LAST_I);
  localparam logic        EN     = (WINDOW_CYCLES > 0);

  logic [TW-1:0] r_timer;
  logic          w_at_last;

  assign w_at_last = (r_timer == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (i_clear || !EN) begin
      r_timer <= '0;
    end else if (i_run) begin
      r_timer <= w_at_last ? '0 : r_timer + 1'b1;
    end
  end

  // A clear cycle owns the timer, so an expiry coinciding with it is void.
  assign o_expire = EN && i_run && !i_clear && w_at_last;

endmodule

// File: rtl/pmc_ctrl.sv
// rtl/pmc_ctrl.sv - performance-monitor counter control and readout sequencer
// Purpose: accepts START/STOP/CLEAR/DUMP commands, drives the PMC unit's
//          count enable and clear, snapshots the four counters atomically and
//          streams them as four words; optional periodic auto-dump.
// Ports:   clk    system clock
//          reset  async active-low reset
//          bus    pmc_ctrl_if.slave (command, counters, controls, dump stream)
module pmc_ctrl
  import pmc_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 0,
  parameter int          CNT_W         = 32
) (
  input logic       clk,
  input logic       reset,
  pmc_ctrl_if.slave bus
);
  pmc_state_e       r_state, w_state_nxt;
  logic             r_run;
  logic             r_ovr;
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_snap [4];

  pmc_cmd_e w_op;
  logic     w_expire;
  logic     w_ready;
  logic     w_acc;
  logic     w_dump_start;
  logic     w_hs;
  logic     w_in_clr;

  assign w_op     = pmc_cmd_e'(bus.cmd_op);
  assign w_in_clr = (r_state == ST_CLR);
  assign w_acc    = bus.cmd_valid && w_ready;
  assign w_hs     = (r_state == ST_DUMP) && bus.dump_ready;

  pmc_window_timer #(.WINDOW_CYCLES(WINDOW_CYCLES)) u_timer (
    .clk      (clk),
    .rst_n    (reset),
    .i_run    (r_run),
    .i_clear  (w_in_clr),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // An expiry in IDLE deasserts cmd_ready, so it takes priority over any
  // pending command, which simply waits for the next IDLE cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_ready      = 1'b0;
    w_dump_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = !w_expire;
        if (w_expire || (bus.cmd_valid && w_op == CMD_DUMP)) begin
          w_dump_start = 1'b1;
          w_state_nxt  = ST_DUMP;
        end else if (bus.cmd_valid && w_op == CMD_CLEAR) begin
          w_state_nxt = ST_CLR;
        end
      end
      ST_CLR:  w_state_nxt = ST_IDLE;
      ST_DUMP: if (w_hs && r_idx == IDX_MEM) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run <= 1'b0;
      r_ovr <= 1'b0;
      r_idx <= IDX_STALL;
      for (int i = 0; i < 4; i++) r_snap[i] <= '0;
    end else begin
      if (w_acc && w_op == CMD_START) r_run <= 1'b1;
      else if (w_acc && w_op == CMD_STOP) r_run <= 1'b0;

      if (w_in_clr) r_ovr <= 1'b0;
      else if (w_expire && r_state != ST_IDLE) r_ovr <= 1'b1;

      // idx wraps back to 0 after the last word, leaving it ready for IDLE.
      if (w_dump_start) r_idx <= IDX_STALL;
      else if (w_hs)    r_idx <= r_idx + 2'd1;

      if (w_dump_start) begin
        r_snap[IDX_STALL] <= bus.stall_count;
        r_snap[IDX_INSTR] <= bus.instr_cycle_count;
        r_snap[IDX_ARITH] <= bus.arith_count;
        r_snap[IDX_MEM]   <= bus.mem_access_count;
      end
    end
  end

  assign bus.cmd_ready    = w_ready;
  assign bus.pmc_enable   = r_run;
  assign bus.pmc_clear    = w_in_clr;
  assign bus.dump_valid   = (r_state == ST_DUMP);
  assign bus.dump_data    = bus.dump_valid ? r_snap[r_idx] : '0;
  assign bus.dump_idx     = r_idx;
  assign bus.dump_last    = bus.dump_valid && (r_idx == IDX_MEM);
  assign bus.dump_overrun = r_ovr;

endmodule

// File: tb/tb_pmc_ctrl.sv
// tb/tb_pmc_ctrl.sv - self-checking bench for pmc_ctrl (timer off and 8-cycle window)
module tb_pmc_ctrl;
  import pmc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cv [2];
  logic [1:0]  op;
  logic        rdy;
  logic [31:0] cnt [4];
  int          checks = 0;
  int          fails  = 0;

  always #5 clk = ~clk;

  pmc_ctrl_if #(.CNT_W(32)) if0 ();
  pmc_ctrl_if #(.CNT_W(32)) if1 ();

  assign if0.cmd_valid = cv[0];
  assign if1.cmd_valid = cv[1];
  assign if0.cmd_op = op;
  assign if1.cmd_op = op;
  assign if0.dump_ready = rdy;
  assign if1.dump_ready = rdy;
  assign if0.stall_count = cnt[0];
  assign if1.stall_count = cnt[0];
  assign if0.instr_cycle_count = cnt[1];
  assign if1.instr_cycle_count = cnt[1];
  assign if0.arith_count = cnt[2];
  assign if1.arith_count = cnt[2];
  assign if0.mem_access_count = cnt[3];
  assign if1.mem_access_count = cnt[3];

  pmc_ctrl #(.WINDOW_CYCLES(0), .CNT_W(32)) dut0 (.clk(clk), .reset(rst_n), .bus(if0));
  pmc_ctrl #(.WINDOW_CYCLES(8), .CNT_W(32)) dut1 (.clk(clk), .reset(rst_n), .bus(if1));

  // Reference model: run flag, window count, phase (0 idle, 1 clear, 2 dump),
  // snapshot words and number of words still to deliver.
  int          wc [2];
  bit          m_run [2];
  bit          m_ovr [2];
  int          m_tmr [2];
  int          m_ph [2];
  int          m_left [2];
  logic [31:0] m_snap [2][4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_exp(input int k);
    return (wc[k] > 0) && m_run[k] && (m_ph[k] != 1) && (m_tmr[k] == wc[k] - 1);
  endfunction

  function automatic bit m_rdy(input int k);
    return (m_ph[k] == 0) && !m_exp(k);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_ovr[k] = 0; m_tmr[k] = 0; m_ph[k] = 0; m_left[k] = 0;
      for (int i = 0; i < 4; i++) m_snap[k][i] = '0;
    end
  endtask

  task automatic m_step(input int k);
    bit ex, acc;
    ex  = m_exp(k);
    acc = cv[k] && m_rdy(k);
    if (m_ph[k] == 1) begin
      m_tmr[k] = 0;
      m_ovr[k] = 0;
    end else begin
      if (wc[k] > 0 && m_run[k]) m_tmr[k] = (m_tmr[k] + 1) % wc[k];
      if (ex && m_ph[k] != 0) m_ovr[k] = 1;
    end
    case (m_ph[k])
      0: begin
        if (ex || (acc && op == CMD_DUMP)) begin
          for (int i = 0; i < 4; i++) m_snap[k][i] = cnt[i];
          m_left[k] = 4;
          m_ph[k]   = 2;
        end else if (acc && op == CMD_CLEAR) begin
          m_ph[k] = 1;
        end
      end
      1: m_ph[k] = 0;
      default: if (rdy) begin
        m_left[k]--;
        if (m_left[k] == 0) m_ph[k] = 0;
      end
    endcase
    if (acc && op == CMD_START) m_run[k] = 1;
    if (acc && op == CMD_STOP)  m_run[k] = 0;
  endtask

  task automatic check_dut(input int k);
    logic r, e, c, v, l, ov;
    logic [1:0]  ix;
    logic [31:0] d;
    bit          ev;
    if (k == 0) begin
      r = if0.cmd_ready; e = if0.pmc_enable; c = if0.pmc_clear; v = if0.dump_valid;
      l = if0.dump_last; ov = if0.dump_overrun; ix = if0.dump_idx; d = if0.dump_data;
    end else begin
      r = if1.cmd_ready; e = if1.pmc_enable; c = if1.pmc_clear; v = if1.dump_valid;
      l = if1.dump_last; ov = if1.dump_overrun; ix = if1.dump_idx; d = if1.dump_data;
    end
    ev = (m_ph[k] == 2);
    chk($sformatf("d%0d_cmd_ready", k), r, m_rdy(k));
    chk($sformatf("d%0d_pmc_enable", k), e, m_run[k]);
    chk($sformatf("d%0d_pmc_clear", k), c, m_ph[k] == 1);
    chk($sformatf("d%0d_dump_valid", k), v, ev);
    chk($sformatf("d%0d_dump_idx", k), ix, ev ? 4 - m_left[k] : 0);
    chk($sformatf("d%0d_dump_last", k), l, ev && m_left[k] == 1);
    chk($sformatf("d%0d_dump_data", k), d, ev ? m_snap[k][4 - m_left[k]] : 32'd0);
    chk($sformatf("d%0d_dump_overrun", k), ov, m_ovr[k]);
  endtask

  task automatic tick();
    check_dut(0);
    check_dut(1);
    if (rst_n) begin
      m_step(0);
      m_step(1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [1:0] o);
    bit acc;
    op = o;
    cv[k] = 1'b1;
    acc = 0;
    for (int i = 0; i < 30 && !acc; i++) begin
      acc = m_rdy(k);
      tick();
    end
    cv[k] = 1'b0;
    chk("send_accepted", acc, 1);
  endtask

  task automatic rand_cnt();
    for (int i = 0; i < 4; i++) cnt[i] = $urandom;
  endtask

  initial begin
    logic [31:0] e5 [4];
    int          hs, lasts;
    e5[0] = 32'd5; e5[1] = 32'd20; e5[2] = 32'd7; e5[3] = 32'd3;
    wc[0] = 0; wc[1] = 8;
    rst_n = 1'b0; cv[0] = 1'b0; cv[1] = 1'b0; op = 2'd0; rdy = 1'b0;
    for (int i = 0; i < 4; i++) cnt[i] = '0;
    m_reset();
    @(posedge clk); #1;
    tick();
    chk("rst_cmd_ready", if0.cmd_ready, 1);
    chk("rst_enable", if0.pmc_enable, 0);
    chk("rst_dump_valid", if1.dump_valid, 0);
    chk("rst_overrun", if1.dump_overrun, 0);
    rst_n = 1'b1;

    // Start/stop latency on the timer-less instance
    tick();
    send(0, CMD_START);
    chk("start_enable", if0.pmc_enable, 1);
    for (int i = 0; i < 7; i++) tick();
    send(0, CMD_STOP);
    chk("stop_enable", if0.pmc_enable, 0);

    // Atomic snapshot with known values, counters scrambled during the stream
    rdy = 1'b1;
    cnt[0] = 32'd5; cnt[1] = 32'd20; cnt[2] = 32'd7; cnt[3] = 32'd3;
    send(0, CMD_DUMP);
    for (int i = 0; i < 4; i++) begin
      rand_cnt();
      chk("dump_word", if0.dump_data, e5[i]);
      chk("dump_word_idx", if0.dump_idx, i);
      chk("dump_word_last", if0.dump_last, i == 3);
      tick();
    end
    chk("dump_done_valid", if0.dump_valid, 0);
    chk("dump_done_ready", if0.cmd_ready, 1);

    // Back-pressured stream
    rand_cnt();
    send(0, CMD_DUMP);
    hs = 0;
    for (int i = 0; i < 21; i++) begin
      rdy = (i % 3 == 0);
      if (if0.dump_valid && rdy) hs++;
      tick();
    end
    chk("stall_handshakes", hs, 4);
    rdy = 1'b1;

    // Clear while running
    send(0, CMD_START);
    tick();
    send(0, CMD_CLEAR);
    chk("clr_pulse", if0.pmc_clear, 1);
    chk("clr_enable", if0.pmc_enable, 1);
    chk("clr_ready", if0.cmd_ready, 0);
    tick();
    chk("clr_pulse_end", if0.pmc_clear, 0);
    chk("clr_ready_back", if0.cmd_ready, 1);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      rand_cnt();
      rdy = 1'($urandom_range(0, 1));
      cv[0] = 1'($urandom_range(0, 1));
      op = 2'($urandom_range(0, 3));
      tick();
    end
    cv[0] = 1'b0;
    rdy = 1'b1;
    for (int i = 0; i < 8; i++) tick();

    // Window timer: auto-dumps every 8 run cycles
    send(1, CMD_START);
    lasts = 0;
    for (int i = 0; i < 32; i++) begin
      if (if1.dump_valid && if1.dump_last && rdy) lasts++;
      rand_cnt();
      tick();
    end
    chk("auto_dumps", lasts, 3);

    // Stalled consumer across an expiry sets the sticky overrun
    rdy = 1'b0;
    for (int i = 0; i < 40 && !if1.dump_overrun; i++) tick();
    chk("overrun_set", if1.dump_overrun, 1);
    rdy = 1'b1;
    send(1, CMD_CLEAR);
    tick();
    chk("overrun_cleared", if1.dump_overrun, 0);

    // DUMP command presented on the expiry cycle waits behind the auto-dump
    for (int i = 0; i < 20; i++) begin
      if (m_exp(1)) break;
      rand_cnt();
      tick();
    end
    chk("expiry_blocks_cmd", if1.cmd_ready, 0);
    send(1, CMD_DUMP);
    chk("cmd_dump_started", if1.dump_valid, 1);
    chk("cmd_dump_idx0", if1.dump_idx, 0);

    // Reset mid-stream
    rdy = 1'b0;
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("mid_rst_valid", if1.dump_valid, 0);
    chk("mid_rst_ready", if1.cmd_ready, 1);
    chk("mid_rst_enable", if1.pmc_enable, 0);
    chk("mid_rst_data", if1.dump_data, 0);
    @(posedge clk); #1;
    tick();
    rst_n = 1'b1;
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/pmc_ctrl.md
Name: pmc_ctrl

Overview:
Control and readout sequencer for the performance-monitor counter unit (stall, instruction-cycle, arithmetic and memory-access counters). It accepts START, STOP, CLEAR and DUMP commands over a valid/ready port and drives the counter unit's count-enable and clear. It snapshots all four 32-bit counters atomically and streams them out as four words over a valid/ready dump port. An optional window timer triggers periodic auto-dumps while counting is enabled.

Parameters:
WINDOW_CYCLES, 0, auto-dump period in clk cycles while running; 0 disables the timer.
CNT_W, 32, width of each counter and of dump_data.

Ports:
clk  input  1  single system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
cmd_valid  input  1  command request.
cmd_op  input  2  0=START, 1=STOP, 2=CLEAR, 3=DUMP.
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
stall_count  input  CNT_W  live counter from the PMC unit.
instr_cycle_count  input  CNT_W  live counter.
arith_count  input  CNT_W  live counter.
mem_access_count  input  CNT_W  live counter.
pmc_enable  output  1  count enable to the PMC unit (registered).
pmc_clear  output  1  one-cycle clear pulse to the PMC unit (registered).
dump_valid  output  1  dump word valid.
dump_ready  input  1  consumer ready.
dump_data  output  CNT_W  snapshot word.
dump_idx  output  2  word index: 0=stall, 1=instr_cycle, 2=arith, 3=mem_access.
dump_last  output  1  high with idx 3.
dump_overrun  output  1  sticky: a window expiry was dropped.

Behaviour:
- Reset (async assert, sync release): state IDLE, run_q=0, timer=0, snapshot regs=0, dump_overrun=0. Every output is 0 except cmd_ready, which is then 1.
- FSM states:
  - IDLE: cmd_ready = !win_expire.
  - CLR: one cycle, pmc_clear=1.
  - DUMP: streams 4 words.
- pmc_enable = run_q.
  - START: sets run_q; takes effect the cycle after acceptance.
  - STOP: clears run_q; takes effect the cycle after acceptance.
  - START/STOP do not leave IDLE. START while running and STOP while stopped are no-ops.
- CLEAR accepted: next cycle is CLR, with pmc_clear high for exactly 1 cycle. In the same cycle, timer and dump_overrun are zeroed. run_q is unchanged. Return to IDLE.
- DUMP accepted: all four counters captured into snapshot regs on the acceptance edge, in the same cycle, atomically. Next cycle enters DUMP with dump_valid=1, dump_idx=0.
  - idx advances on dump_valid && dump_ready.
  - dump_data, dump_idx and dump_last stay stable while stalled.
  - After the idx-3 handshake: dump_valid drops next cycle and the FSM returns to IDLE.
  - Minimum DUMP-to-IDLE time is 4 cycles with dump_ready held at 1.
- Counting continues during DUMP; the snapshot is unaffected.
- Window timer (WINDOW_CYCLES>0):
  - Increments each cycle run_q=1, holds when run_q=0.
  - win_expire when timer==WINDOW_CYCLES-1; the timer then wraps to 0.
  - Expiry in IDLE: identical to an accepted DUMP. It wins over a simultaneous cmd_valid, because cmd_ready is 0 that cycle and the command waits.
  - Expiry outside IDLE: dropped and dump_overrun set (sticky until CLEAR or reset).
- WINDOW_CYCLES=0: timer is held at 0, win_expire never asserts.
- Reset asserted mid-dump: immediately abandons the stream. dump_valid=0 asynchronously.
- cmd_ready is 0 in CLR and DUMP; commands are never dropped, only back-pressured.

Decomposition:
- Package pmc_pkg holds:
  - pmc_cmd_e (START/STOP/CLEAR/DUMP).
  - pmc_state_e (IDLE/CLR/DUMP).
  - Dump-index localparams IDX_STALL..IDX_MEM.
- One sub-module, pmc_window_timer. Inputs: run, clear, WINDOW_CYCLES. Output: expire pulse.
- pmc_ctrl holds the FSM, run flag, snapshot registers and dump mux.

Test Plan:
1. Reset release, START at cycle 2 -> pmc_enable=1 from cycle 3; STOP at cycle 10 -> pmc_enable=0 from cycle 11; cmd_ready=1 throughout.
2. Counters at 5/20/7/3, DUMP with dump_ready=1 -> words 5,20,7,3 on idx 0..3, dump_last only on word 4; counters changing during the stream do not alter the data.
3. DUMP with dump_ready toggling 1,0,0,1... -> each word is held stable while stalled; exactly 4 handshakes; cmd_ready returns 1 only after the last handshake.
4. CLEAR while running -> single-cycle pmc_clear, pmc_enable stays 1, cmd_ready=0 for that one cycle.
5. WINDOW_CYCLES=8, START, dump_ready=1 -> auto-dump every 8 run cycles. Then hold dump_ready=0 across a second expiry -> dump_overrun=1; CLEAR clears it.
6. cmd_valid DUMP on the expiry cycle -> auto-dump taken, command accepted after it completes. Assert reset mid-dump -> all outputs return to reset values.
